// File: rtl/riscv_v_elastic_pipe_pkg.sv
// Shared constants and helpers for the vector-unit elastic pipeline slice.
package riscv_v_pipe_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  // $clog2 clamped to at least 1 so a counter port never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned w;
    w = $clog2(value);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/riscv_v_elastic_pipe_if.sv
// Valid/ready payload handshake between vector pipeline segments.
interface riscv_v_elastic_pipe_if
  import riscv_v_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  // master drives the upstream side and consumes the downstream side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/riscv_v_elastic_slot.sv
// One pipeline slot: valid bit plus payload register with load/hold/flush.
module riscv_v_elastic_slot #(
  parameter int unsigned      WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= RST_VAL;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= prev_valid;
      // bubbles move through without disturbing the held payload
      if (prev_valid) data <= prev_data;
    end
  end

endmodule

// File: rtl/riscv_v_elastic_pipe.sv
// Multi-stage elastic pipeline register with bubble collapsing, flush and occupancy.
module riscv_v_elastic_pipe
  import riscv_v_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH      = DEFAULT_WIDTH,
  parameter int unsigned      NUM_STAGES = 2,
  parameter logic [WIDTH-1:0] RST_VAL    = '0,
  parameter int unsigned      CNT_W      = clog2_min1(NUM_STAGES + 1),
  localparam int unsigned     SV_W       = (NUM_STAGES == 0) ? 1 : NUM_STAGES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  riscv_v_elastic_pipe_if.slave   bus,
  output logic [SV_W-1:0]         stage_valid,
  output logic [SV_W*WIDTH-1:0]   stage_data,
  output logic [CNT_W-1:0]        occupancy
);

  if (NUM_STAGES == 0) begin : g_pass
    assign bus.out_valid = bus.in_valid;
    assign bus.out_data  = bus.in_data;
    assign bus.in_ready  = bus.out_ready && !flush;
    assign stage_valid   = '0;
    assign stage_data    = {SV_W{RST_VAL}};
    assign occupancy     = '0;
  end else begin : g_pipe
    logic [NUM_STAGES:0]   rdy;
    logic [NUM_STAGES-1:0] valid;
    logic [WIDTH-1:0]      data_q [NUM_STAGES];
    logic                  in_fire;
    logic                  out_fire;

    // a stage can move when it is empty or everything after it can move
    always_comb begin
      rdy             = '0;
      rdy[NUM_STAGES] = bus.out_ready;
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
        rdy[NUM_STAGES-1-k] = !valid[NUM_STAGES-1-k] || rdy[NUM_STAGES-k];
      end
    end

    assign bus.in_ready  = rdy[0] && !flush && rst_n;
    assign bus.out_valid = valid[NUM_STAGES-1];
    assign bus.out_data  = data_q[NUM_STAGES-1];
    assign stage_valid   = valid;
    assign in_fire       = bus.in_valid && bus.in_ready;
    assign out_fire      = bus.out_valid && bus.out_ready;

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_slot
      logic             prev_valid;
      logic [WIDTH-1:0] prev_data;

      if (i == 0) begin : g_head
        assign prev_valid = bus.in_valid;
        assign prev_data  = bus.in_data;
      end else begin : g_link
        assign prev_valid = valid[i-1];
        assign prev_data  = data_q[i-1];
      end

      riscv_v_elastic_slot #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
      ) u_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .load       (rdy[i]),
        .prev_valid (prev_valid),
        .prev_data  (prev_data),
        .valid      (valid[i]),
        .data       (data_q[i])
      );

      assign stage_data[i*WIDTH +: WIDTH] = data_q[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        occupancy <= '0;
      end else if (flush) begin
        occupancy <= '0;
      end else begin
        occupancy <= occupancy + CNT_W'(in_fire) - CNT_W'(out_fire);
      end
    end
  end

endmodule

// File: tb/tb_riscv_v_elastic_pipe.sv
// Bench for riscv_v_elastic_pipe: 3-stage and pass-through instances, 8-bit payload.
module tb_riscv_v_elastic_pipe;
  import riscv_v_pipe_pkg::*;

  localparam logic [7:0] RV = 8'hE7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush3 = 1'b0;
  logic flush0 = 1'b0;
  always #5 clk = ~clk;

  riscv_v_elastic_pipe_if #(.WIDTH(8)) b3 ();
  riscv_v_elastic_pipe_if #(.WIDTH(8)) b0 ();

  logic [2:0]  sv3;
  logic [23:0] sd3;
  logic [1:0]  occ3;
  logic [0:0]  sv0;
  logic [7:0]  sd0;
  logic [0:0]  occ0;

  riscv_v_elastic_pipe #(
    .WIDTH (8), .NUM_STAGES (3), .RST_VAL (RV)
  ) u3 (
    .clk (clk), .rst_n (rst_n), .flush (flush3), .bus (b3),
    .stage_valid (sv3), .stage_data (sd3), .occupancy (occ3)
  );

  riscv_v_elastic_pipe #(
    .WIDTH (8), .NUM_STAGES (0), .RST_VAL (RV)
  ) u0 (
    .clk (clk), .rst_n (rst_n), .flush (flush0), .bus (b0),
    .stage_valid (sv0), .stage_data (sd0), .occupancy (occ0)
  );

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       fl;
    logic       exp_ir;
    logic       exp_ov;
    logic [1:0] exp_occ;
    logic [2:0] exp_sv;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  function automatic vec_t row(input logic iv, input logic [7:0] id, input logic ordy,
                               input logic fl, input logic ir, input logic ov,
                               input logic [1:0] occ, input logic [2:0] sv);
    vec_t r;
    r.iv = iv; r.id = id; r.ordy = ordy; r.fl = fl;
    r.exp_ir = ir; r.exp_ov = ov; r.exp_occ = occ; r.exp_sv = sv;
    return r;
  endfunction

  // Called mid-cycle, before the next rising edge.
  task automatic sample_sb();
    if (b3.out_valid && b3.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got %0h want none", b3.out_data);
      end else begin
        chk("sb_data", {24'h0, b3.out_data}, {24'h0, exp_q.pop_front()});
      end
    end
    if (flush3) exp_q.delete();
    if (b3.in_valid && b3.in_ready) exp_q.push_back(b3.in_data);
  endtask

  task automatic drive_cycle(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
    b3.in_valid = iv; b3.in_data = id; b3.out_ready = ordy; flush3 = fl;
    #4;
    sample_sb();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    b3.in_valid = 1'b0; b3.in_data = '0; b3.out_ready = 1'b0;
    b0.in_valid = 1'b0; b0.in_data = '0; b0.out_ready = 1'b0;

    // reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ov", {31'h0, b3.out_valid}, 32'h0);
    chk("rst_ir", {31'h0, b3.in_ready}, 32'h0);
    chk("rst_sv", {29'h0, sv3}, 32'h0);
    chk("rst_occ", {30'h0, occ3}, 32'h0);
    chk("rst_sd", {8'h0, sd3}, {8'h0, RV, RV, RV});
    rst_n = 1'b1;

    // streaming
    vecs.push_back(row(1, 8'h11, 1, 0, 1, 0, 0, 3'b000));
    vecs.push_back(row(1, 8'h22, 1, 0, 1, 0, 1, 3'b001));
    vecs.push_back(row(1, 8'h33, 1, 0, 1, 0, 2, 3'b011));
    vecs.push_back(row(0, 8'h00, 1, 0, 1, 1, 3, 3'b111));
    vecs.push_back(row(0, 8'h00, 1, 0, 1, 1, 2, 3'b110));
    vecs.push_back(row(0, 8'h00, 1, 0, 1, 1, 1, 3'b100));
    vecs.push_back(row(0, 8'h00, 1, 0, 1, 0, 0, 3'b000));
    // backpressure, then simultaneous pop and push while full
    vecs.push_back(row(1, 8'hA1, 0, 0, 1, 0, 0, 3'b000));
    vecs.push_back(row(1, 8'hA2, 0, 0, 1, 0, 1, 3'b001));
    vecs.push_back(row(1, 8'hA3, 0, 0, 1, 0, 2, 3'b011));
    vecs.push_back(row(1, 8'hA4, 0, 0, 0, 1, 3, 3'b111));
    vecs.push_back(row(1, 8'hA4, 1, 0, 1, 1, 3, 3'b111));
    vecs.push_back(row(0, 8'h00, 1, 0, 1, 1, 3, 3'b111));
    vecs.push_back(row(0, 8'h00, 1, 0, 1, 1, 2, 3'b110));
    vecs.push_back(row(0, 8'h00, 1, 0, 1, 1, 1, 3'b100));
    vecs.push_back(row(0, 8'h00, 1, 0, 1, 0, 0, 3'b000));
    // bubble collapse
    vecs.push_back(row(1, 8'h55, 0, 0, 1, 0, 0, 3'b000));
    vecs.push_back(row(0, 8'h00, 0, 0, 1, 0, 1, 3'b001));
    vecs.push_back(row(1, 8'h66, 0, 0, 1, 0, 1, 3'b010));
    vecs.push_back(row(0, 8'h00, 0, 0, 1, 1, 2, 3'b101));
    vecs.push_back(row(0, 8'h00, 0, 0, 1, 1, 2, 3'b110));
    vecs.push_back(row(0, 8'h00, 1, 0, 1, 1, 2, 3'b110));
    vecs.push_back(row(0, 8'h00, 1, 0, 1, 1, 1, 3'b100));
    vecs.push_back(row(0, 8'h00, 1, 0, 1, 0, 0, 3'b000));
    // flush of a full pipe with a payload offered
    vecs.push_back(row(1, 8'hB1, 0, 0, 1, 0, 0, 3'b000));
    vecs.push_back(row(1, 8'hB2, 0, 0, 1, 0, 1, 3'b001));
    vecs.push_back(row(1, 8'hB3, 0, 0, 1, 0, 2, 3'b011));
    vecs.push_back(row(1, 8'h77, 0, 1, 0, 1, 3, 3'b111));
    vecs.push_back(row(0, 8'h00, 1, 0, 1, 0, 0, 3'b000));
    vecs.push_back(row(0, 8'h00, 1, 0, 1, 0, 0, 3'b000));
    vecs.push_back(row(0, 8'h00, 1, 0, 1, 0, 0, 3'b000));

    foreach (vecs[i]) begin
      b3.in_valid = vecs[i].iv; b3.in_data = vecs[i].id;
      b3.out_ready = vecs[i].ordy; flush3 = vecs[i].fl;
      #4;
      chk($sformatf("v%0d_ir", i), {31'h0, b3.in_ready}, {31'h0, vecs[i].exp_ir});
      chk($sformatf("v%0d_ov", i), {31'h0, b3.out_valid}, {31'h0, vecs[i].exp_ov});
      chk($sformatf("v%0d_occ", i), {30'h0, occ3}, {30'h0, vecs[i].exp_occ});
      chk($sformatf("v%0d_sv", i), {29'h0, sv3}, {29'h0, vecs[i].exp_sv});
      sample_sb();
      @(posedge clk);
      #1;
    end
    chk("sb_drained", exp_q.size(), 0);

    // asynchronous reset mid-stream
    drive_cycle(1, 8'hC1, 0, 0);
    drive_cycle(1, 8'hC2, 0, 0);
    drive_cycle(1, 8'hC3, 0, 0);
    b3.in_valid = 1'b0;
    chk("pre_rst_ov", {31'h0, b3.out_valid}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_ov", {31'h0, b3.out_valid}, 32'h0);
    chk("arst_sv", {29'h0, sv3}, 32'h0);
    chk("arst_occ", {30'h0, occ3}, 32'h0);
    chk("arst_sd", {8'h0, sd3}, {8'h0, RV, RV, RV});
    chk("arst_ir", {31'h0, b3.in_ready}, 32'h0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive_cycle(1, 8'h99, 1, 0);
    lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      b3.in_valid = 1'b0; b3.out_ready = 1'b1; flush3 = 1'b0;
      #4;
      if (b3.out_valid) lat = c;
      sample_sb();
      @(posedge clk);
      #1;
    end
    chk("post_rst_latency", lat, 3);
    chk("post_rst_drained", exp_q.size(), 0);

    // pass-through instance
    for (int i = 0; i < 4; i++) begin
      logic [7:0] d;
      d = 8'h3C + 8'(i);
      b0.in_valid = 1'b1; b0.in_data = d; b0.out_ready = i[0]; flush0 = 1'b0;
      #4;
      chk($sformatf("p%0d_ov", i), {31'h0, b0.out_valid}, 32'h1);
      chk($sformatf("p%0d_od", i), {24'h0, b0.out_data}, {24'h0, d});
      chk($sformatf("p%0d_ir", i), {31'h0, b0.in_ready}, {31'h0, i[0]});
      chk($sformatf("p%0d_occ", i), {31'h0, occ0}, 32'h0);
      chk($sformatf("p%0d_sv", i), {31'h0, sv0}, 32'h0);
      chk($sformatf("p%0d_sd", i), {24'h0, sd0}, {24'h0, RV});
      @(posedge clk);
      #1;
    end
    b0.out_ready = 1'b1; flush0 = 1'b1;
    #4;
    chk("p_flush_ir", {31'h0, b0.in_ready}, 32'h0);
    chk("p_flush_ov", {31'h0, b0.out_valid}, 32'h1);
    @(posedge clk);
    #1 flush0 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/riscv_v_elastic_pipe.md
Name: riscv_v_elastic_pipe

Overview:
- Parametrised multi-stage pipeline register with a per-stage valid/ready handshake, synchronous flush and bubble collapsing.
- Generalises the fixed 1-bit enable-shift delay line to WIDTH-bit payloads.
- Stalls only those stages that are blocked downstream; downstream bubbles keep filling.
- Sits between vector-unit pipeline segments (decode→issue, lane ALU→writeback) and exports per-stage state for hazard and forwarding checks.

Parameters:
- WIDTH, 32, payload width in bits (≥1).
- NUM_STAGES, 2, number of register stages (≥0; 0 = combinational pass-through).
- RST_VAL, '0, WIDTH-bit value loaded into every stage data register on reset.
- CNT_W, $clog2(NUM_STAGES+1) (min 1), width of the occupancy count.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous pipeline kill.
- in_valid  input  1  upstream payload valid.
- in_data  input  WIDTH  upstream payload.
- in_ready  output  1  pipe can accept in_data this cycle.
- out_valid  output  1  last stage holds a valid payload.
- out_data  output  WIDTH  last-stage payload.
- out_ready  input  1  downstream accepts this cycle.
- stage_valid  output  max(NUM_STAGES,1)  valid bit per stage, bit 0 = first stage.
- stage_data  output  max(NUM_STAGES,1)*WIDTH  flattened stage payloads, stage i at [i*WIDTH +: WIDTH].
- occupancy  output  CNT_W  number of set stage_valid bits.

Behaviour:
- Reset (rst_n=0, async): all valid bits 0, all data = RST_VAL, occupancy 0.
  - During reset out_valid=0, in_ready=0.
  - On the first cycle after release in_ready=1.
- Ready chain, combinational: rdy[N] = out_ready; rdy[i] = !valid[i] || rdy[i+1]; in_ready = rdy[0] && !flush && rst_n.
- Load rule: stage i loads from stage i-1 (stage 0 from in_data/in_valid) when rdy[i]=1.
  - valid[i] <= valid[i-1]; data[i] <= data[i-1] only if valid[i-1]=1. Otherwise data holds.
  - A non-loading stage holds both valid and data.
- Fire events: in_fire = in_valid && in_ready; out_fire = out_valid && out_ready.
- Latency: NUM_STAGES cycles from in_fire to out_valid when unstalled. Throughput 1 payload/cycle.
- Bubble collapse: with out_ready=0, upstream stages keep advancing until contiguous from the last stage.
  - in_ready falls only when all NUM_STAGES stages are valid.
- Full and simultaneous in_fire/out_fire: both happen in the same cycle, occupancy unchanged, no loss or duplication.
- Flush: next edge clears all valid bits; data registers hold. Priority over load.
  - in_ready=0 in the flush cycle, so an offered in_valid is not accepted.
  - out_valid is still driven during the flush cycle. An out_fire in that cycle counts; downstream ignores the payload if required.
- Occupancy: registered; occupancy <= occupancy + in_fire - out_fire. Flush sets it to 0. It always equals popcount(stage_valid).
- NUM_STAGES=0:
  - out_valid=in_valid, out_data=in_data, in_ready=out_ready && !flush.
  - stage_valid=0, stage_data=RST_VAL, occupancy=0. No registers.
- Reset asserted mid-operation: contents are discarded immediately (async), matching the reset state above.
- in_data is not sampled when in_valid=0. Payload X-propagation is not masked.

Decomposition:
- Shared package riscv_v_pipe_pkg: default WIDTH constant and a clog2-with-min-1 function for CNT_W.
- One natural sub-module, riscv_v_elastic_slot: single valid+data register with the load/hold/flush rule, instantiated NUM_STAGES times in a generate loop.
- Top level holds the ready chain, the occupancy counter and the NUM_STAGES=0 pass-through.

Test Plan:
- WIDTH=8, N=3: stream 0x11,0x22,0x33 back-to-back with out_ready=1 → out_valid rises 3 cycles after the first in_fire; outputs in order, one per cycle; occupancy peaks at 3.
- N=3, out_ready=0: offer 0xA1..0xA4 → three accepted; in_ready=0 on the 4th offer with occupancy=3. Raise out_ready → 0xA1 pops and 0xA4 is accepted in the same cycle; occupancy stays 3.
- N=3: insert 0x55, idle one cycle, insert 0x66, hold out_ready=0 → the bubble collapses; stage_valid=3'b110 two cycles after 0x66; in_ready stays 1.
- N=3, pipe full: pulse flush with in_valid=1 (0x77) → in_ready=0 that cycle; next cycle stage_valid=0, occupancy=0, 0x77 never emerges.
- Assert rst_n=0 asynchronously mid-stream (between edges) → out_valid and stage_valid go 0 immediately; stage_data=RST_VAL. After release, a single 0x99 emerges after 3 cycles.
- N=0: in_valid=1, in_data=0x3C, out_ready toggling → out_data=0x3C the same cycle; in_ready follows out_ready; occupancy=0.
